// File: rtl/seg_count_decoder_if.sv
// Result channel of the 7-segment count decoder.
// Ports: valid/ready handshake, count, comps, err (+ ovr with SEG_OVERRUN_FLAG_EN).
interface seg_count_decoder_if;
    logic       valid;
    logic       ready;
    logic [2:0] count;
    logic [4:0] comps;
    logic       err;
`ifdef SEG_OVERRUN_FLAG_EN
    logic       ovr;

    modport master (
        output valid, count, comps, err, ovr,
        input  ready
    );
    modport slave (
        input  valid, count, comps, err, ovr,
        output ready
    );
`else
    modport master (
        output valid, count, comps, err,
        input  ready
    );
    modport slave (
        input  valid, count, comps, err,
        output ready
    );
`endif
endinterface

// File: rtl/seg_count_decoder.sv
// Debounces a 7-segment bus and decodes settled digits 0..5 to count/thermometer.
// Ports: clk, rst_n (async low), segs[6:0] async {g..a}, bus (master: valid/ready/
// count/comps/err). Define SEG_OVERRUN_FLAG_EN to add bus.ovr overrun flag.
module seg_count_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          segs,
    seg_count_decoder_if.master bus
);

    localparam logic [6:0] BLANK    = 7'h7F;
    localparam logic [2:0] STAB_MAX = 3'(STABLE_CYCLES);
    localparam logic [2:0] STAB_ACC = 3'(STABLE_CYCLES - 1);

    logic [6:0] seg_n;
    logic [6:0] s1, s2;
    logic [6:0] cand;
    logic [6:0] last_acc;
    logic [2:0] stab;

    logic       accept;
    logic       event_hit;
    logic       dec_ok;
    logic [2:0] dec_cnt;
    logic [4:0] dec_comps;

    // Per-bit inversion ahead of the synchroniser keeps the
    // reset value 7'h7F meaning "blank" for both polarities.
    assign seg_n = ACTIVE_LOW ? segs : ~segs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= BLANK;
            s2 <= BLANK;
        end else begin
            s1 <= seg_n;
            s2 <= s1;
        end
    end

    assign accept    = (s2 == cand) && (stab == STAB_ACC);
    assign event_hit = accept && (cand != last_acc)
                     && (cand != BLANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= BLANK;
            stab     <= '0;
            last_acc <= BLANK;
        end else begin
            if (s2 != cand) begin
                cand <= s2;
                stab <= 3'd1;
            end else if (stab < STAB_MAX) begin
                stab <= stab + 3'd1;
            end
            if (accept)
                last_acc <= cand;
        end
    end

    always_comb begin
        dec_ok    = 1'b1;
        dec_cnt   = 3'd0;
        dec_comps = 5'b00000;
        case (cand)
            7'h40: begin dec_cnt = 3'd0; dec_comps = 5'b00000; end
            7'h79: begin dec_cnt = 3'd1; dec_comps = 5'b00001; end
            7'h24: begin dec_cnt = 3'd2; dec_comps = 5'b00011; end
            7'h30: begin dec_cnt = 3'd3; dec_comps = 5'b00111; end
            7'h19: begin dec_cnt = 3'd4; dec_comps = 5'b01111; end
            7'h12: begin dec_cnt = 3'd5; dec_comps = 5'b11111; end
            default: dec_ok = 1'b0;
        endcase
    end

    // Single-entry slot: a new event always wins, even over
    // a word that is still waiting for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid <= 1'b0;
            bus.count <= '0;
            bus.comps <= '0;
            bus.err   <= 1'b0;
`ifdef SEG_OVERRUN_FLAG_EN
            bus.ovr   <= 1'b0;
`endif
        end else if (event_hit) begin
            bus.valid <= 1'b1;
            bus.count <= dec_cnt;
            bus.comps <= dec_comps;
            bus.err   <= ~dec_ok;
`ifdef SEG_OVERRUN_FLAG_EN
            bus.ovr   <= bus.valid && !bus.ready;
`endif
        end else if (bus.valid && bus.ready) begin
            bus.valid <= 1'b0;
`ifdef SEG_OVERRUN_FLAG_EN
            bus.ovr   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_seg_count_decoder.sv
// Directed self-checking bench for seg_count_decoder.
// Drives segs/ready after each edge and samples 1ns later.
module tb_seg_count_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] segs;
    int         tests;
    int         fails;

    seg_count_decoder_if bus ();

    seg_count_decoder #(
        .STABLE_CYCLES(4),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .segs (segs),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag,
                              input logic [2:0] c,
                              input logic [4:0] m,
                              input logic e);
        check({tag, ".valid"}, {7'd0, bus.valid}, 8'd1);
        check({tag, ".count"}, {5'd0, bus.count}, {5'd0, c});
        check({tag, ".comps"}, {3'd0, bus.comps}, {3'd0, m});
        check({tag, ".err"},   {7'd0, bus.err},   {7'd0, e});
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        segs      = 7'h7F;
        bus.ready = 1'b0;
        tick(3);
        check("rst.valid", {7'd0, bus.valid}, 8'd0);
        check("rst.count", {5'd0, bus.count}, 8'd0);
        check("rst.comps", {3'd0, bus.comps}, 8'd0);
        check("rst.err",   {7'd0, bus.err},   8'd0);
        rst_n = 1'b1;
        tick(8);
        check("blank_idle", {7'd0, bus.valid}, 8'd0);

        // clean digit 3, exact latency
        segs = 7'h30;
        tick(5);
        check("lat_early", {7'd0, bus.valid}, 8'd0);
        tick(1);
        check_word("d3", 3'd3, 5'b00111, 1'b0);
        tick(3);
        check_word("d3_hold", 3'd3, 5'b00111, 1'b0);
        bus.ready = 1'b1;
        tick(1);
        check("d3_xfer", {7'd0, bus.valid}, 8'd0);

        // digit 2 then a short glitch
        bus.ready = 1'b0;
        segs = 7'h24;
        tick(8);
        check_word("d2", 3'd2, 5'b00011, 1'b0);
        bus.ready = 1'b1;
        tick(1);
        check("d2_xfer", {7'd0, bus.valid}, 8'd0);
        bus.ready = 1'b0;
        segs = 7'h79;
        tick(2);
        segs = 7'h24;
        tick(12);
        check("glitch", {7'd0, bus.valid}, 8'd0);

        // illegal pattern, reported once
        segs = 7'h00;
        tick(8);
        check_word("ill", 3'd0, 5'b00000, 1'b1);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        tick(8);
        check("ill_once", {7'd0, bus.valid}, 8'd0);

        // digit 4, blank, digit 4 again
        segs = 7'h19;
        tick(8);
        check_word("d4a", 3'd4, 5'b01111, 1'b0);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        segs = 7'h7F;
        tick(6);
        check("blank_ev", {7'd0, bus.valid}, 8'd0);
        segs = 7'h19;
        tick(6);
        check_word("d4b", 3'd4, 5'b01111, 1'b0);
        bus.ready = 1'b1;
        tick(1);
        check("d4b_xfer", {7'd0, bus.valid}, 8'd0);

        // overrun: 1 then 5 without consuming
        bus.ready = 1'b0;
        segs = 7'h79;
        tick(8);
        check_word("ov1", 3'd1, 5'b00001, 1'b0);
`ifdef SEG_OVERRUN_FLAG_EN
        check("ov1.ovr", {7'd0, bus.ovr}, 8'd0);
`endif
        segs = 7'h12;
        tick(8);
        check_word("ov5", 3'd5, 5'b11111, 1'b0);
`ifdef SEG_OVERRUN_FLAG_EN
        check("ov5.ovr", {7'd0, bus.ovr}, 8'd1);
`endif
        bus.ready = 1'b1;
        tick(1);
        check("ov_xfer", {7'd0, bus.valid}, 8'd0);
`ifdef SEG_OVERRUN_FLAG_EN
        check("ov_clr.ovr", {7'd0, bus.ovr}, 8'd0);
`endif

        // mid-operation reset with digit 1 held
        bus.ready = 1'b0;
        segs = 7'h79;
        tick(8);
        check_word("pre_rst", 3'd1, 5'b00001, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr.valid", {7'd0, bus.valid}, 8'd0);
        check("mr.count", {5'd0, bus.count}, 8'd0);
        check("mr.comps", {3'd0, bus.comps}, 8'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("mr_early", {7'd0, bus.valid}, 8'd0);
        tick(1);
        check_word("mr_d1", 3'd1, 5'b00001, 1'b0);
        tick(6);
        check_word("mr_hold", 3'd1, 5'b00001, 1'b0);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        tick(8);
        check("mr_once", {7'd0, bus.valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
